// File: rtl/eth_udp_chdr_extract.sv
// Ethernet/IPv4/UDP header stripper for CHDR-over-UDP.
// Filters on local MAC/IP/port and emits the UDP payload realigned to 64 bits.
module eth_udp_chdr_extract #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [47:0]      cfg_mac,
    input  logic [31:0]      cfg_ip,
    input  logic [15:0]      cfg_udp_port,
    input  logic [63:0]      s_axis_tdata,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [63:0]      m_axis_tdata,
    output logic [15:0]      m_axis_tuser,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        HDR,
        PAYLOAD,
        FLUSH,
        DROP
    } state_t;

    state_t           state_q;
    logic [2:0]       wcnt_q;
    logic [47:0]      mac_q;
    logic [23:0]      eth_q;
    logic [7:0]       proto_q;
    logic [15:0]      iphi_q;
    logic [15:0]      len_q;
    logic [12:0]      rem_q;
    logic             first_q;
    logic [47:0]      hold_q;
    logic [CNT_W-1:0] drop_q;
    logic [CNT_W-1:0] err_q;

    logic        s_fire;
    logic        m_free;
    logic        hdr_ok;
    logic        drop_ev;
    logic        err_ev;
    logic [15:0] udp_len;
    logic [15:0] pay_len;

    assign udp_len = s_axis_tdata[15:0];
    assign pay_len = udp_len - 16'd8;
    assign m_free  = !m_axis_tvalid || m_axis_tready;
    assign s_fire  = s_axis_tvalid && s_axis_tready;

    // Payload words can only be taken when the output register is free.
    assign s_axis_tready = rst_n &&
        ((state_q != PAYLOAD) || m_free);

    assign drop_count = drop_q;
    assign err_count  = err_q;

    // Header acceptance, evaluated while word 4 is on the bus.
    always_comb begin
        hdr_ok = (mac_q == cfg_mac) &&
                 (eth_q == 24'h080045) &&
                 (proto_q == 8'd17) &&
                 ({iphi_q, s_axis_tdata[63:48]} == cfg_ip) &&
                 (s_axis_tdata[31:16] == cfg_udp_port) &&
                 (udp_len >= 16'd16) &&
                 (udp_len[2:0] == 3'd0);
    end

    // Drop (runt or filtered header) and truncated-payload events.
    always_comb begin
        drop_ev = 1'b0;
        err_ev  = 1'b0;
        if (s_fire && (state_q == HDR)) begin
            drop_ev = s_axis_tlast ||
                      ((wcnt_q == 3'd4) && !hdr_ok);
        end
        if (s_fire && (state_q == PAYLOAD)) begin
            err_ev = s_axis_tlast &&
                     (first_q || (rem_q != 13'd1));
        end
    end

    // Parser FSM with the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HDR;
            wcnt_q        <= 3'd0;
            mac_q         <= 48'd0;
            eth_q         <= 24'd0;
            proto_q       <= 8'd0;
            iphi_q        <= 16'd0;
            len_q         <= 16'd0;
            rem_q         <= 13'd0;
            first_q       <= 1'b0;
            hold_q        <= 48'd0;
            m_axis_tdata  <= 64'd0;
            m_axis_tuser  <= 16'd0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (s_fire) begin
                unique case (state_q)
                    HDR: begin
                        if (s_axis_tlast) begin
                            wcnt_q <= 3'd0;
                        end else begin
                            case (wcnt_q)
                                3'd0: mac_q   <= s_axis_tdata[63:16];
                                3'd1: eth_q   <= s_axis_tdata[31:8];
                                3'd2: proto_q <= s_axis_tdata[7:0];
                                3'd3: iphi_q  <= s_axis_tdata[15:0];
                                default: ;
                            endcase
                            if (wcnt_q == 3'd4) begin
                                wcnt_q <= 3'd0;
                                if (hdr_ok) begin
                                    state_q <= PAYLOAD;
                                    len_q   <= pay_len;
                                    rem_q   <= pay_len[15:3];
                                    first_q <= 1'b1;
                                end else begin
                                    state_q <= DROP;
                                end
                            end else begin
                                wcnt_q <= wcnt_q + 3'd1;
                            end
                        end
                    end
                    PAYLOAD: begin
                        hold_q  <= s_axis_tdata[47:0];
                        first_q <= 1'b0;
                        if (first_q) begin
                            if (s_axis_tlast) begin
                                state_q <= HDR;
                            end
                        end else begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= {hold_q,
                                              s_axis_tdata[63:48]};
                            m_axis_tuser  <= len_q;
                            m_axis_tlast  <= (rem_q == 13'd1) ||
                                             s_axis_tlast;
                            rem_q         <= rem_q - 13'd1;
                            if (rem_q == 13'd1) begin
                                state_q <= s_axis_tlast ? HDR : FLUSH;
                            end else if (s_axis_tlast) begin
                                state_q <= HDR;
                            end
                        end
                    end
                    FLUSH, DROP: begin
                        if (s_axis_tlast) begin
                            state_q <= HDR;
                        end
                    end
                endcase
            end
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
            err_q  <= '0;
        end else begin
            if (drop_ev && (drop_q != {CNT_W{1'b1}})) begin
                drop_q <= drop_q + CNT_W'(1);
            end
            if (err_ev && (err_q != {CNT_W{1'b1}})) begin
                err_q <= err_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_eth_udp_chdr_extract.sv
// Randomized bench for eth_udp_chdr_extract.
// Frames are built as byte arrays; the model derives payload words from bytes.
module tb_eth_udp_chdr_extract;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [47:0]   cfg_mac;
    logic [31:0]   cfg_ip;
    logic [15:0]   cfg_udp_port;
    logic [63:0]   s_tdata;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [63:0]   m_tdata;
    logic [15:0]   m_tuser;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] err_count;

    eth_udp_chdr_extract #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_mac       (cfg_mac),
        .cfg_ip        (cfg_ip),
        .cfg_udp_port  (cfg_udp_port),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .drop_count    (drop_count),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  fb [0:2047];
    int          fn;
    int          e_drop;
    int          e_err;
    bit          stall_en;
    bit          gaps_en;
    logic [63:0] exp_d [$];
    logic [15:0] exp_u [$];
    logic        exp_l [$];
    logic [63:0] got_d [$];
    logic [15:0] got_u [$];
    logic        got_l [$];
    int          got_base;
    int          hold_err = 0;

    // Output monitor: collects accepted beats and flags stall instability.
    logic        prev_stall = 1'b0;
    logic [63:0] pd;
    logic [15:0] pu;
    logic        pl;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall &&
                (!m_tvalid || m_tdata !== pd ||
                 m_tuser !== pu || m_tlast !== pl)) begin
                hold_err++;
            end
            if (m_tvalid && m_tready) begin
                got_d.push_back(m_tdata);
                got_u.push_back(m_tuser);
                got_l.push_back(m_tlast);
            end
            prev_stall = m_tvalid && !m_tready;
            pd = m_tdata;
            pu = m_tuser;
            pl = m_tlast;
        end
    end

    // Downstream ready, optionally randomized.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    function automatic logic [63:0] wd(input int b);
        logic [63:0] w = 64'd0;
        for (int j = 0; j < 8; j++) w = {w[55:0], fb[b + j]};
        return w;
    endfunction

    task automatic build(input int ul, input int n, input int bad);
        for (int i = 0; i < 8 * n + 48; i++) fb[i] = 8'($urandom);
        for (int j = 0; j < 6; j++) fb[j] = cfg_mac[47 - 8 * j -: 8];
        fb[12] = 8'h08;
        fb[13] = 8'h00;
        fb[14] = 8'h45;
        fb[23] = 8'd17;
        for (int j = 0; j < 4; j++) fb[30 + j] = cfg_ip[31 - 8 * j -: 8];
        fb[36] = cfg_udp_port[15:8];
        fb[37] = cfg_udp_port[7:0];
        fb[38] = 8'(ul >> 8);
        fb[39] = 8'(ul);
        case (bad)
            1: fb[$urandom_range(0, 5)] ^= 8'h10;
            2: fb[12] ^= 8'h01;
            3: fb[14] ^= 8'h01;
            4: fb[23] ^= 8'h02;
            5: fb[30 + $urandom_range(0, 3)] ^= 8'h80;
            6: fb[37] ^= 8'h04;
            default: ;
        endcase
        fn = n;
    endtask

    task automatic model();
        bit acc;
        int ul, w, avail, nout;
        ul = {fb[38], fb[39]};
        acc = ({fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]} == cfg_mac) &&
              ({fb[12], fb[13]} == 16'h0800) &&
              (fb[14] == 8'h45) && (fb[23] == 8'd17) &&
              ({fb[30], fb[31], fb[32], fb[33]} == cfg_ip) &&
              ({fb[36], fb[37]} == cfg_udp_port) &&
              (ul >= 16) && (ul % 8 == 0);
        if (fn <= 5 || !acc) begin
            if (e_drop < SAT) e_drop++;
        end else begin
            w = (ul - 8) / 8;
            avail = fn - 6;
            nout = (avail < w) ? avail : w;
            for (int k = 0; k < nout; k++) begin
                exp_d.push_back(wd(42 + 8 * k));
                exp_u.push_back(16'(ul - 8));
                exp_l.push_back(k == nout - 1);
            end
            if (avail < w && e_err < SAT) e_err++;
        end
    endtask

    task automatic send_words(input int upto, output int stalls);
        int  bound;
        bit  done;
        stalls = 0;
        for (int i = 0; i < upto; i++) begin
            if (gaps_en && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_tdata  = wd(8 * i);
            s_tlast  = (i == fn - 1);
            s_tvalid = 1'b1;
            bound = 0;
            done  = 0;
            while (!done) begin
                @(negedge clk);
                if (s_tready) begin
                    done = 1;
                end else begin
                    stalls++;
                    bound++;
                    if (bound > 2000) begin
                        check("send_timeout", 64'd0, 64'd1);
                        done = 1;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic run_frame(input int ul, input int n,
                             input int bad, output int stalls);
        int t;
        int ng;
        build(ul, n, bad);
        model();
        send_words(n, stalls);
        t = 0;
        while ((got_d.size() - got_base < exp_d.size() || m_tvalid)
               && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        ng = got_d.size() - got_base;
        check("n_out", 64'(ng), 64'(exp_d.size()));
        for (int k = 0; k < ng && k < exp_d.size(); k++) begin
            check("out_data", got_d[got_base + k], exp_d[k]);
            check("out_user", 64'(got_u[got_base + k]), 64'(exp_u[k]));
            check("out_last", 64'(got_l[got_base + k]), 64'(exp_l[k]));
        end
        got_base = got_d.size();
        exp_d.delete();
        exp_u.delete();
        exp_l.delete();
        check("drop_cnt", 64'(drop_count), 64'(e_drop));
        check("err_cnt", 64'(err_count), 64'(e_err));
        check("stall_hold", 64'(hold_err), 64'd0);
    endtask

    initial begin
        int st;
        int ul, n, bad, l;
        cfg_mac      = {16'($urandom), $urandom};
        cfg_ip       = $urandom;
        cfg_udp_port = 16'($urandom);
        s_tdata  = 64'd0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        stall_en = 0;
        gaps_en  = 0;
        e_drop   = 0;
        e_err    = 0;
        got_base = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mvalid", 64'(m_tvalid), 64'd0);
        check("rst_mlast", 64'(m_tlast), 64'd0);
        check("rst_mdata", m_tdata, 64'd0);
        check("rst_muser", 64'(m_tuser), 64'd0);
        check("rst_sready", 64'(s_tready), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("hdr_sready", 64'(s_tready), 64'd1);

        run_frame(32, 9, 0, st);
        run_frame(40, 12, 6, st);
        check("drop_rdy", 64'(st), 64'd0);
        run_frame(48, 12, 0, st);
        run_frame(16, 8, 0, st);
        run_frame(24, 8, 0, st);

        stall_en = 1;
        run_frame(1032, 6 + 128 + 1, 0, st);
        stall_en = 0;

        run_frame(72, 8, 0, st);
        run_frame(40, 3, 0, st);
        run_frame(40, 6, 0, st);
        run_frame(40, 5, 0, st);

        for (int i = 0; i < 40; i++) begin
            stall_en = $urandom_range(0, 1) == 1;
            gaps_en  = $urandom_range(0, 1) == 1;
            bad = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 6);
            l   = 8 * $urandom_range(1, 40);
            ul  = l + 8;
            n   = 6 + l / 8 + $urandom_range(0, 3);
            case ($urandom_range(0, 5))
                0: begin
                    ul = $urandom_range(0, 400);
                    n  = $urandom_range(6, 60);
                end
                1: n = $urandom_range(1, 6 + l / 8);
                default: ;
            endcase
            run_frame(ul, n, bad, st);
        end
        stall_en = 0;
        gaps_en  = 0;

        for (int i = 0; i < 18; i++) begin
            run_frame(40, $urandom_range(1, 5), 0, st);
        end

        build(1032, 6 + 128 + 1, 0);
        send_words(40, st);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_mvalid", 64'(m_tvalid), 64'd0);
        check("mid_rst_mdata", m_tdata, 64'd0);
        check("mid_rst_muser", 64'(m_tuser), 64'd0);
        check("mid_rst_mlast", 64'(m_tlast), 64'd0);
        check("mid_rst_sready", 64'(s_tready), 64'd0);
        check("mid_rst_drop", 64'(drop_count), 64'd0);
        check("mid_rst_err", 64'(err_count), 64'd0);
        e_drop = 0;
        e_err  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        got_base = got_d.size();
        @(posedge clk);
        #1;
        run_frame(64, 14, 0, st);
        run_frame(32, 9, 0, st);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
